// File: rtl/attractor_classifier_if.sv
// -----------------------------------------------------------------------------
// attractor_classifier_if
//   Bundles the trajectory input and classification result signals of
//   attractor_classifier.
//   master : drives start / x_in, observes the result (testbench or upstream).
//   slave  : the classifier itself.
//   Optional min_state result is present only when ATTR_MIN_STATE_EN is defined.
// -----------------------------------------------------------------------------
interface attractor_classifier_if #(
   parameter int DEPTH = 16,
   parameter int W     = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          start;
   logic [W-1:0]  x_in;
   logic          busy;
   logic          done;
   logic          is_fixed;
   logic          is_cycle;
   logic          overflow;
   logic [CW-1:0] period;
   logic [CW-1:0] transient;
   logic [W-1:0]  entry;
`ifdef ATTR_MIN_STATE_EN
   logic [W-1:0]  min_state;
`endif

   modport master (
      output start, x_in,
      input  busy, done, is_fixed, is_cycle, overflow, period, transient, entry
`ifdef ATTR_MIN_STATE_EN
      , input min_state
`endif
   );

   modport slave (
      input  start, x_in,
      output busy, done, is_fixed, is_cycle, overflow, period, transient, entry
`ifdef ATTR_MIN_STATE_EN
      , output min_state
`endif
   );
endinterface

// File: rtl/attractor_classifier.sv
// -----------------------------------------------------------------------------
// attractor_classifier
//   Records a state trajectory (one W-bit state per clock) and detects the
//   first repeated state. Reports the attractor period, the transient length
//   and the entry state, or overflow when DEPTH distinct states are seen.
//
//   Ports:
//     clk  - single clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - attractor_classifier_if.slave
//            start/x_in in; busy, done, is_fixed, is_cycle, overflow,
//            period, transient, entry (and min_state) out, all registered.
//
//   Optional feature macro: ATTR_MIN_STATE_EN
//     Adds min_state = minimum of the states on the attractor cycle
//     (hist[j..count-1]) as a canonical attractor ID, same timing as entry.
// -----------------------------------------------------------------------------
module attractor_classifier #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   attractor_classifier_if.slave  bus
);

   localparam int CW = $clog2(DEPTH) + 1;   // count/period/transient width
   localparam int IW = $clog2(DEPTH);       // history index width

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t        state_q,     state_d;
   logic [CW-1:0] count_q,     count_d;
   logic          busy_q,      busy_d;
   logic          done_q,      done_d;
   logic          is_fixed_q,  is_fixed_d;
   logic          is_cycle_q,  is_cycle_d;
   logic          overflow_q,  overflow_d;
   logic [CW-1:0] period_q,    period_d;
   logic [CW-1:0] transient_q, transient_d;
   logic [W-1:0]  entry_q,     entry_d;
`ifdef ATTR_MIN_STATE_EN
   logic [W-1:0]  min_state_q, min_state_d;
   logic [W-1:0]  cycle_min;
`endif

   // History buffer is deliberately not reset: only indices below count
   // ever take part in a comparison.
   logic [W-1:0]  hist_q [DEPTH];
   logic          hist_we;
   logic [IW-1:0] hist_wr_idx;

   logic [DEPTH-1:0] match_vec;
   logic             match_any;
   logic [IW-1:0]    match_idx;
   logic [CW-1:0]    period_calc;

   // Parallel compare of x_in against every valid history entry.
   always_comb begin
      match_vec = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < count_q) && (hist_q[k] == bus.x_in)) begin
            match_vec[k] = 1'b1;
         end else begin
            match_vec[k] = 1'b0;
         end
      end
   end

   // Priority encoder: scanning downward leaves the lowest matching index.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (match_vec[k]) begin
            match_any = 1'b1;
            match_idx = IW'(k);
         end else begin
            match_idx = match_idx;
         end
      end
      period_calc = count_q - {1'b0, match_idx};
   end

`ifdef ATTR_MIN_STATE_EN
   // Minimum over the cycle portion hist[match_idx..count-1]; computed in the
   // same cycle as the match so the result lands with entry.
   always_comb begin
      cycle_min = {W{1'b1}};
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) >= {1'b0, match_idx}) && (CW'(k) < count_q) &&
             (hist_q[k] < cycle_min)) begin
            cycle_min = hist_q[k];
         end else begin
            cycle_min = cycle_min;
         end
      end
   end
`endif

   // Next-state and next-output computation for the classifier FSM.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      is_fixed_d  = is_fixed_q;
      is_cycle_d  = is_cycle_q;
      overflow_d  = overflow_q;
      period_d    = period_q;
      transient_d = transient_q;
      entry_d     = entry_q;
`ifdef ATTR_MIN_STATE_EN
      min_state_d = min_state_q;
`endif
      hist_we     = 1'b0;
      hist_wr_idx = '0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               hist_we     = 1'b1;
               hist_wr_idx = '0;
               count_d     = CW'(1);
               busy_d      = 1'b1;
               is_fixed_d  = 1'b0;
               is_cycle_d  = 1'b0;
               overflow_d  = 1'b0;
               period_d    = '0;
               transient_d = '0;
               entry_d     = '0;
`ifdef ATTR_MIN_STATE_EN
               min_state_d = '0;
`endif
               state_d     = S_COLLECT;
            end else begin
               busy_d      = 1'b0;
            end
         end

         // start is intentionally ignored here, including on the done edge.
         S_COLLECT: begin
            if (match_any) begin
               period_d    = period_calc;
               transient_d = {1'b0, match_idx};
               entry_d     = hist_q[match_idx];
               is_fixed_d  = (period_calc == CW'(1));
               is_cycle_d  = (period_calc > CW'(1));
`ifdef ATTR_MIN_STATE_EN
               min_state_d = cycle_min;
`endif
               done_d      = 1'b1;
               busy_d      = 1'b0;
               state_d     = S_DONE;
            end else if (count_q < CW'(DEPTH)) begin
               hist_we     = 1'b1;
               hist_wr_idx = count_q[IW-1:0];
               count_d     = count_q + CW'(1);
            end else begin
               overflow_d  = 1'b1;
               period_d    = '0;
               transient_d = '0;
               entry_d     = '0;
               is_fixed_d  = 1'b0;
               is_cycle_d  = 1'b0;
`ifdef ATTR_MIN_STATE_EN
               min_state_d = '0;
`endif
               done_d      = 1'b1;
               busy_d      = 1'b0;
               state_d     = S_DONE;
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // FSM state, counter and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         is_fixed_q  <= 1'b0;
         is_cycle_q  <= 1'b0;
         overflow_q  <= 1'b0;
         period_q    <= '0;
         transient_q <= '0;
         entry_q     <= '0;
`ifdef ATTR_MIN_STATE_EN
         min_state_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         is_fixed_q  <= is_fixed_d;
         is_cycle_q  <= is_cycle_d;
         overflow_q  <= overflow_d;
         period_q    <= period_d;
         transient_q <= transient_d;
         entry_q     <= entry_d;
`ifdef ATTR_MIN_STATE_EN
         min_state_q <= min_state_d;
`endif
      end
   end

   // History write port.
   always_ff @(posedge clk) begin
      if (hist_we) begin
         hist_q[hist_wr_idx] <= bus.x_in;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.is_fixed  = is_fixed_q;
   assign bus.is_cycle  = is_cycle_q;
   assign bus.overflow  = overflow_q;
   assign bus.period    = period_q;
   assign bus.transient = transient_q;
   assign bus.entry     = entry_q;
`ifdef ATTR_MIN_STATE_EN
   assign bus.min_state = min_state_q;
`endif

endmodule

// File: doc/attractor_classifier.md
ATTRACTOR_CLASSIFIER -- requirements
Module: attractor_classifier

Interface
REQ-001 Parameter DEPTH, default 16, history depth in states (power of two, 2..32).
REQ-002 Parameter W, default 8, state width in bits (matches gene_net x_out).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin classifying the trajectory on x_in.
REQ-006 x_in  input  W  current network state, one new state per clock (driven by gene_net x_out).
REQ-007 busy  output  1  high while collecting.
REQ-008 done  output  1  one-cycle pulse when a result is valid.
REQ-009 is_fixed  output  1  attractor has period 1.
REQ-010 is_cycle  output  1  attractor has period >= 2.
REQ-011 overflow  output  1  DEPTH states stored with no repeat.
REQ-012 period  output  log2(DEPTH)+1  attractor period, i - j.
REQ-013 transient  output  log2(DEPTH)+1  steps before entering the attractor, j.
REQ-014 entry  output  W  first repeated state, hist[j].

Function
REQ-015 FSM states IDLE, COLLECT, DONE; reset enters IDLE.
REQ-016 IDLE/DONE + start at edge 0: hist[0] <= x_in, count <= 1, clear result outputs, go to COLLECT, busy high from next cycle.
REQ-017 COLLECT, each edge: compare x_in against hist[0..count-1] in parallel, all in one cycle.
REQ-018 Match at index j: register period=count-j, transient=j, entry=hist[j], is_fixed=(period==1), is_cycle=(period>1), done=1 for one cycle, go to DONE.
REQ-019 Stored entries are distinct, so at most one match occurs; the encoder still selects lowest j.
REQ-020 No match and count<DEPTH: hist[count] <= x_in, count++.
REQ-021 No match and count==DEPTH: overflow=1, period=0, transient=0, entry=0, is_fixed=is_cycle=0, done pulse, go to DONE.
REQ-022 Latency: trajectory x_k sampled at edge k; with x_{t+p}=x_t, done is high in the cycle after edge t+p.
REQ-023 start during COLLECT is ignored; start coincident with the done edge is ignored.
REQ-024 In DONE, result outputs hold until the next accepted start; busy=0, done=0 after the pulse.
REQ-025 Arithmetic unsigned; count, period and transient are log2(DEPTH)+1 bits wide and never wrap.

Reset
REQ-026 rst high asynchronously forces IDLE, count=0, and all outputs to 0 (busy, done, is_fixed, is_cycle, overflow, period, transient, entry).
REQ-027 History contents need not be cleared; entries at index >= count are never compared.
REQ-028 rst mid-COLLECT aborts with no done pulse; the first start after rst deasserts operates normally.

Configuration
REQ-029 Macro ATTR_MIN_STATE_EN defined: add output min_state (W bits) = minimum of hist[j..count-1] at match (a canonical attractor ID, same timing as entry, 0 on reset/overflow); the extra stage shall not lengthen latency.
REQ-030 ATTR_MIN_STATE_EN undefined: no min_state port or logic; all other behaviour identical.

Verification
REQ-031 start with x_in held 0x53 -> done after edge 1: is_fixed=1, period=1, transient=0, entry=0x53.
REQ-032 stream 0x00,0x53,0x53 -> done after edge 2: is_fixed=1, period=1, transient=1, entry=0x53.
REQ-033 stream 0x38,0x1C,0xB2,0x1C -> done after edge 3: is_cycle=1, period=2, transient=1, entry=0x1C; with macro min_state=0x1C.
REQ-034 17 distinct values 0x00..0x10 (DEPTH=16) -> done after edge 16: overflow=1, is_fixed=is_cycle=0, period=0.
REQ-035 rst pulse at edge 2 of COLLECT -> all outputs 0 immediately, no done; a later start with 0x53 held gives the REQ-031 result.
REQ-036 start re-pulsed at edge 1 of a 0x38,0x1C,0xB2,0x1C run -> ignored; result identical to REQ-033.
